// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC commit stage.
package npc_pkg;
  localparam int          XLEN        = 64;
  localparam int          NR_GPR      = 32;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam int          REG_A0      = 10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } commit_state_e;
endpackage

// File: rtl/gpr_file.sv
// 1W/2R general-purpose register file with x0 tied to zero and a flattened snapshot.
// Same-cycle write-to-read forwarding is enabled by defining WB_BYPASS_EN.
module gpr_file
  import npc_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = NR_GPR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_we,
  input  logic [4:0]     i_waddr,
  input  logic [W-1:0]   i_wdata,
  input  logic [4:0]     i_rs1_addr,
  input  logic [4:0]     i_rs2_addr,
  output logic [W-1:0]   o_rs1_data,
  output logic [W-1:0]   o_rs2_data,
  output logic [N*W-1:0] o_rf_flat
);
  logic [W-1:0] r_regs [N];
  logic         w_wr_live;
  logic         w_byp1;
  logic         w_byp2;

  assign w_wr_live = i_we && (i_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
`ifdef WB_BYPASS_EN
    w_byp1 = w_wr_live && (i_waddr == i_rs1_addr);
    w_byp2 = w_wr_live && (i_waddr == i_rs2_addr);
`endif
    o_rs1_data = '0;
    o_rs2_data = '0;
    if (i_rs1_addr != 5'd0) o_rs1_data = w_byp1 ? i_wdata : r_regs[i_rs1_addr];
    if (i_rs2_addr != 5'd0) o_rs2_data = w_byp2 ? i_wdata : r_regs[i_rs2_addr];
  end

  // Snapshot always reflects post-edge state; bypass never applies here.
  for (genvar g = 0; g < N; g++) begin : g_flat
    if (g == 0) begin : g_zero
      assign o_rf_flat[g*W +: W] = '0;
    end else begin : g_reg
      assign o_rf_flat[g*W +: W] = r_regs[g];
    end
  end
endmodule

// File: rtl/wb_commit.sv
// Commit stage: writeback handshake, retire bookkeeping and ebreak halt sequencing.
// Optional macro WB_BYPASS_EN enables same-cycle forwarding in the register file.
//
// state     | meaning
// ST_RUN    | accepting retiring instructions
// ST_DRAIN  | ebreak retired, waiting one cycle before sampling a0
// ST_HALTED | halted until rst, is_break raised
module wb_commit
  import npc_pkg::*;
#(
  parameter int NR_GPR_P = NR_GPR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [31:0]              wb_inst,
  input  logic                     wb_rd_en,
  input  logic [4:0]               wb_rd_addr,
  input  logic [XLEN-1:0]          wb_rd_data,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     commit_valid,
  output logic [XLEN-1:0]          commit_pc,
  output logic [31:0]              commit_inst,
  output logic [XLEN-1:0]          instret,
  output logic                     is_break,
  output logic [XLEN-1:0]          halt_code,
  output logic [NR_GPR_P*XLEN-1:0] rf_flat
);
  commit_state_e   r_state;
  logic            r_ready;
  logic            r_commit_valid;
  logic [XLEN-1:0] r_commit_pc;
  logic [31:0]     r_commit_inst;
  logic [XLEN-1:0] r_instret;
  logic            r_is_break;
  logic [XLEN-1:0] r_halt_code;

  logic            w_xfer;
  logic            w_is_ebreak;
  logic            w_rf_we;
  logic [XLEN-1:0] w_a0;

  assign w_xfer      = wb_valid && r_ready;
  assign w_is_ebreak = (wb_inst == INST_EBREAK);
  assign w_rf_we     = w_xfer && wb_rd_en && !w_is_ebreak;
  assign w_a0        = rf_flat[REG_A0*XLEN +: XLEN];

  gpr_file #(.W(XLEN), .N(NR_GPR_P)) u_gpr (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_rf_we),
    .i_waddr    (wb_rd_addr),
    .i_wdata    (wb_rd_data),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .o_rf_flat  (rf_flat)
  );

  // wb_ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_ready        <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
      r_commit_inst  <= '0;
      r_instret      <= '0;
      r_is_break     <= 1'b0;
      r_halt_code    <= '0;
    end else begin
      r_commit_valid <= w_xfer;
      if (w_xfer) begin
        r_commit_pc   <= wb_pc;
        r_commit_inst <= wb_inst;
        r_instret     <= r_instret + {{(XLEN-1){1'b0}}, 1'b1};
      end
      case (r_state)
        ST_RUN: begin
          if (w_xfer && w_is_ebreak) begin
            r_state <= ST_DRAIN;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_halt_code <= w_a0;
          r_state     <= ST_HALTED;
          r_ready     <= 1'b0;
        end
        ST_HALTED: begin
          r_ready    <= 1'b0;
          r_is_break <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready     = r_ready;
  assign commit_valid = r_commit_valid;
  assign commit_pc    = r_commit_pc;
  assign commit_inst  = r_commit_inst;
  assign instret      = r_instret;
  assign is_break     = r_is_break;
  assign halt_code    = r_halt_code;
endmodule

// File: doc/wb_commit.md
# wb_commit

Final pipeline stage of the NPC core: accepts retiring instructions from writeback over a valid/ready handshake and owns the 32×64 general-purpose register file. It publishes the committed PC/instruction and a flattened architectural register snapshot to the simulation DPI model. On `ebreak` it drains and halts, raising `is_break` to end simulation.

## Interface
- `XLEN`, 64, register width.
- `NR_GPR`, 32, number of architectural registers; x0 is hardwired to zero.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  writeback holds a retiring instruction.
- `wb_ready`  out  1  stage accepts this cycle; a transfer occurs when `wb_valid && wb_ready`.
- `wb_pc`  in  XLEN  PC of the retiring instruction.
- `wb_inst`  in  32  raw encoding.
- `wb_rd_en`  in  1  instruction writes rd.
- `wb_rd_addr`  in  5  destination register.
- `wb_rd_data`  in  XLEN  writeback value.
- `rs1_addr`, `rs2_addr`  in  5  decode-stage read addresses.
- `rs1_data`, `rs2_data`  out  XLEN  combinational read data.
- `commit_valid`  out  1  one-cycle pulse per retired instruction.
- `commit_pc`  out  XLEN  PC of the last retired instruction.
- `commit_inst`  out  32  encoding of the last retired instruction.
- `instret`  out  XLEN  retired-instruction count.
- `is_break`  out  1  high while halted after `ebreak`.
- `halt_code`  out  XLEN  value of a0 (x10) captured at halt.
- `rf_flat`  out  NR_GPR*XLEN  architectural GPRs; reg i occupies bits [i*XLEN +: XLEN].

## Operation
- FSM states: RUN, DRAIN, HALTED.
- RUN: `wb_ready`=1. On transfer:
  - If `wb_rd_en` and rd≠0, write rd.
  - Set commit outputs and increment `instret`.
  - If `wb_inst`==32'h0010_0073 (EBREAK), move to DRAIN.
- DRAIN, 1 cycle: `wb_ready`=0. Capture `halt_code` from x10 after the final write has settled. Go to HALTED.
- HALTED: `wb_ready`=0 and `is_break`=1. The stage stays here until `rst`. `wb_valid` is ignored.
- EBREAK itself counts as retired. It never writes a register, even if `wb_rd_en`=1.
- Writes to x0 are discarded. x0 always reads 0, including in `rf_flat`.
- `instret` wraps modulo 2^XLEN.
- Read ports are combinational from the register array. Bypass behaviour is set under Configuration.

## Timing
- Reset values:
  - All GPRs = 0.
  - State = RUN.
  - `wb_ready`=1 one cycle after `rst` deasserts. It is 0 while `rst`=1.
  - `commit_valid`, `is_break`, `commit_pc`, `commit_inst`, `instret`, `halt_code` = 0.
- Commit latency is 1 cycle. A transfer at edge N gives `commit_valid`=1 and updated commit outputs, `instret` and `rf_flat` after edge N, for exactly one cycle.
- `commit_valid` is 0 in any cycle with no transfer in the previous cycle. `commit_pc`/`commit_inst` hold their last values.
- Back-to-back transfers are supported, one per cycle, with no bubble.
- EBREAK timing:
  - EBREAK accepted at edge N: DRAIN holds for cycle N+1.
  - `is_break` rises after edge N+2.
- `rst` in any state, mid-stream or while halted, takes effect at the next edge. It clears everything; no in-flight commit survives.
- `wb_ready` depends only on state, never on `wb_valid`.

## Configuration
- `WB_BYPASS_EN` defined:
  - If a transfer in the same cycle writes rd≠0 and `rsN_addr`==rd, then `rsN_data` returns `wb_rd_data`.
  - Decode sees the value in the same cycle it is written.
- Undefined: `rsN_data` returns the pre-write array value. The new value is visible one cycle later.
- `rf_flat` is always post-edge state and is unaffected by the macro.

## Structure
- Package `npc_pkg` holds:
  - `XLEN`
  - `INST_EBREAK` = 32'h0010_0073
  - `REG_A0` = 10
  - the commit FSM state enum
- Sub-module `gpr_file`: storage with 1 write port and 2 read ports, x0 forced to zero, the optional bypass, and the `rf_flat` output.
- `wb_commit` contains the handshake, the FSM, the commit/instret registers and halt capture.

## Test plan
- Reset, then idle for 5 cycles:
  - `wb_ready`=1.
  - `commit_valid`=0, `instret`=0, `is_break`=0.
  - All of `rf_flat`=0.
- Write x5=64'hDEAD_BEEF at pc=0x8000_0000, then write x0=1:
  - `rf_flat` x5=DEAD_BEEF and x0=0.
  - `commit_pc` follows each instruction.
  - `instret`=2.
- Four back-to-back writes, x1..x4 = 1..4:
  - `commit_valid` high for 4 consecutive cycles.
  - `instret`=4.
  - Values correct.
- Write x7=0x55 while `rs1_addr`=7:
  - With `WB_BYPASS_EN`, `rs1_data`=0x55 in the same cycle.
  - Without it, old value, then 0x55 one cycle later.
- Write x10=0x2A, then EBREAK with `wb_valid` held high afterwards:
  - `wb_ready` drops.
  - `is_break`=1 two edges after EBREAK accept.
  - `halt_code`=0x2A.
  - `instret`=2; no further commits.
- Assert `rst` while halted and during a streaming burst:
  - Next cycle all outputs return to reset values.
  - State is RUN.
